// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multicycle controller.
//   - FSM state encoding (FETCH..WB, codes 5-7 unused)
//   - opcode map, AluOp / PcSrc / instType encodings
//   - latched instruction register type and the control-strobe bundle
//   - small opcode-classification helpers used by the FSM and the decoder
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    OP_AND  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_ADDI = 4'd3,
    OP_ANDI = 4'd4,
    OP_LW   = 4'd5,
    OP_LBU  = 4'd6,
    OP_BEQ  = 4'd7,
    OP_BNE  = 4'd8,
    OP_BGT  = 4'd9,
    OP_BLT  = 4'd10,
    OP_ILL  = 4'd11,
    OP_JMP  = 4'd12,
    OP_CALL = 4'd13,
    OP_RET  = 4'd14,
    OP_SV   = 4'd15
  } opcode_e;

  typedef enum logic [1:0] {
    ALU_AND = 2'b00,
    ALU_ADD = 2'b01,
    ALU_SUB = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_JUMP   = 2'b01,
    PC_BRANCH = 2'b10,
    PC_BUSA   = 2'b11
  } pc_src_e;

  typedef enum logic [1:0] {
    IT_R = 2'b00,
    IT_I = 2'b01,
    IT_J = 2'b10,
    IT_S = 2'b11
  } inst_type_e;

  typedef struct packed {
    opcode_e op;
    logic    m;
  } ir_t;

  typedef struct packed {
    logic       alu_src;
    logic       mem_r;
    logic       mem_w;
    logic       reg_wr;
    logic       reg_des;
    logic       wr_b;
    logic       ext_op;
    logic       r0;
    logic       r7;
    logic       load;
    logic       byte_or_word;
    logic       st;
    alu_op_e    alu_op;
    pc_src_e    pc_src;
    inst_type_e inst_type;
  } ctrl_t;

  function automatic logic is_r_type(opcode_e op);
    return op inside {OP_AND, OP_ADD, OP_SUB};
  endfunction

  function automatic logic is_alu_imm(opcode_e op);
    return op inside {OP_ADDI, OP_ANDI};
  endfunction

  function automatic logic is_load(opcode_e op);
    return op inside {OP_LW, OP_LBU};
  endfunction

  function automatic logic is_branch(opcode_e op);
    return op inside {OP_BEQ, OP_BNE, OP_BGT, OP_BLT};
  endfunction

  // Jumps and the illegal opcode both retire in DECODE.
  function automatic logic ends_in_decode(opcode_e op);
    return op inside {OP_ILL, OP_JMP, OP_CALL, OP_RET};
  endfunction

  function automatic logic uses_mem(opcode_e op);
    return is_load(op) || (op == OP_SV);
  endfunction

  // The illegal opcode reports as R-type; it behaves as a NOP.
  function automatic inst_type_e inst_type_of(opcode_e op);
    inst_type_e t;
    if (is_r_type(op) || op == OP_ILL) t = IT_R;
    else if (op == OP_SV)              t = IT_S;
    else if (op inside {OP_JMP, OP_CALL, OP_RET}) t = IT_J;
    else                               t = IT_I;
    return t;
  endfunction

  // Loads and stores use ADD for address generation.
  function automatic alu_op_e alu_op_of(opcode_e op);
    alu_op_e a;
    if (op inside {OP_AND, OP_ANDI})              a = ALU_AND;
    else if (op == OP_SUB || is_branch(op))       a = ALU_SUB;
    else                                          a = ALU_ADD;
    return a;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational control-strobe decode from FSM state + IR.
//   state     : current FSM state
//   ir        : latched opcode and mode bit
//   z, n      : datapath flags, consulted only for branches in WB
//   mem_ready : memory completion strobe (only used with MEM_WAIT_EN)
//   ctrl      : all datapath control strobes, 0 unless asserted below
// Config macro: MEM_WAIT_EN -- a store retires on the MEM cycle that
//   sees mem_ready high instead of after a single MEM cycle.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  state_e state,
  input  ir_t    ir,
  input  logic   z,
  input  logic   n,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  logic mem_done;
  logic taken;

`ifdef MEM_WAIT_EN
  assign mem_done = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_done = 1'b1;
`endif

  always_comb begin
    taken = 1'b0;
    case (ir.op)
      OP_BEQ:  taken = z;
      OP_BNE:  taken = !z;
      OP_BGT:  taken = !z && !n;
      OP_BLT:  taken = n;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    ctrl = '0;
    ctrl.inst_type = (state == S_FETCH) ? IT_R : inst_type_of(ir.op);
    case (state)
      S_DECODE: begin
        case (ir.op)
          OP_JMP: begin
            ctrl.load   = 1'b1;
            ctrl.pc_src = PC_JUMP;
          end
          OP_CALL: begin
            ctrl.load   = 1'b1;
            ctrl.pc_src = PC_JUMP;
            ctrl.reg_wr = 1'b1;
            ctrl.r7     = 1'b1;
          end
          OP_RET: begin
            ctrl.load   = 1'b1;
            ctrl.pc_src = PC_BUSA;
          end
          OP_ILL: ctrl.load = 1'b1;
          default: ;
        endcase
      end
      S_EXEC: begin
        ctrl.alu_op  = alu_op_of(ir.op);
        ctrl.alu_src = is_alu_imm(ir.op) || is_load(ir.op);
        ctrl.ext_op  = (inst_type_of(ir.op) == IT_I) ? ir.m : 1'b0;
        ctrl.reg_des = is_r_type(ir.op);
      end
      S_MEM: begin
        ctrl.mem_r = is_load(ir.op);
        ctrl.mem_w = (ir.op == OP_SV);
        ctrl.load  = (ir.op == OP_SV) && mem_done;
      end
      S_WB: begin
        ctrl.load         = 1'b1;
        ctrl.reg_des      = is_r_type(ir.op);
        ctrl.reg_wr       = is_r_type(ir.op) || is_alu_imm(ir.op) || is_load(ir.op);
        ctrl.wr_b         = is_load(ir.op);
        ctrl.byte_or_word = (ir.op == OP_LBU);
        ctrl.pc_src       = (is_branch(ir.op) && taken) ? PC_BRANCH : PC_SEQ;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multicycle CPU control unit (FSM + IR latch).
//   clk, reset      : single clock, synchronous active-high reset
//   instruction     : instruction word, opcode [15:12], mode bit [11];
//                     sampled only in FETCH
//   z, n            : registered datapath flags
//   mem_ready       : memory completion strobe (MEM_WAIT_EN only)
//   AluSrc..ST      : 1-bit datapath strobes
//   AluOp, PcSrc,
//   instType        : 2-bit encoded controls
//   state           : current FSM state, for debug
// Config macro: MEM_WAIT_EN -- MEM holds until mem_ready is sampled high.
module multicycle_control
  import ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instruction,
  input  logic        z,
  input  logic        n,
  input  logic        mem_ready,
  output logic        AluSrc,
  output logic        MemR,
  output logic        MemW,
  output logic        RegWr,
  output logic        RegDes,
  output logic        WrB,
  output logic        ExtOp,
  output logic        R0,
  output logic        R7,
  output logic        load,
  output logic        ByteOrWord,
  output logic        ST,
  output logic [1:0]  AluOp,
  output logic [1:0]  PcSrc,
  output logic [1:0]  instType,
  output logic [2:0]  state
);

  state_e state_q, state_d;
  ir_t    ir_q, ir_d;
  ctrl_t  ctrl;
  logic   mem_hold;
  logic   unused_instr;

  assign unused_instr = ^instruction[10:0];

`ifdef MEM_WAIT_EN
  assign mem_hold = !mem_ready;
`else
  assign mem_hold = 1'b0;
`endif

  always_comb begin
    state_d = S_FETCH;
    ir_d    = ir_q;
    case (state_q)
      S_FETCH: begin
        state_d = S_DECODE;
        ir_d    = '{op: opcode_e'(instruction[15:12]), m: instruction[11]};
      end
      S_DECODE: state_d = ends_in_decode(ir_q.op) ? S_FETCH : S_EXEC;
      S_EXEC:   state_d = uses_mem(ir_q.op) ? S_MEM : S_WB;
      S_MEM: begin
        if (mem_hold)                state_d = S_MEM;
        else if (is_load(ir_q.op))   state_d = S_WB;
        else                         state_d = S_FETCH;
      end
      S_WB:    state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  ctrl_decode u_decode (
    .state     (state_q),
    .ir        (ir_q),
    .z         (z),
    .n         (n),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  // Architectural side effects are blocked during the reset cycle itself.
  always_comb begin
    AluSrc     = ctrl.alu_src;
    MemR       = ctrl.mem_r;
    MemW       = ctrl.mem_w && !reset;
    RegWr      = ctrl.reg_wr && !reset;
    RegDes     = ctrl.reg_des;
    WrB        = ctrl.wr_b;
    ExtOp      = ctrl.ext_op;
    R0         = ctrl.r0;
    R7         = ctrl.r7;
    load       = ctrl.load && !reset;
    ByteOrWord = ctrl.byte_or_word;
    ST         = ctrl.st;
    AluOp      = ctrl.alu_op;
    PcSrc      = ctrl.pc_src;
    instType   = ctrl.inst_type;
    state      = state_q;
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control. Builds an expected per-cycle trace
// from the instruction-set rules, drives it, and compares every cycle.
// Works with or without MEM_WAIT_EN defined.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instruction;
  logic        z, n, mem_ready;
  logic        AluSrc, MemR, MemW, RegWr, RegDes, WrB, ExtOp, R0, R7;
  logic        load, ByteOrWord, ST;
  logic [1:0]  AluOp, PcSrc, instType;
  logic [2:0]  state;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .reset(reset), .instruction(instruction), .z(z), .n(n),
    .mem_ready(mem_ready), .AluSrc(AluSrc), .MemR(MemR), .MemW(MemW),
    .RegWr(RegWr), .RegDes(RegDes), .WrB(WrB), .ExtOp(ExtOp), .R0(R0),
    .R7(R7), .load(load), .ByteOrWord(ByteOrWord), .ST(ST), .AluOp(AluOp),
    .PcSrc(PcSrc), .instType(instType), .state(state)
  );

  typedef struct packed {
    logic alu_src, mem_r, mem_w, reg_wr, reg_des, wr_b, ext_op, r0, r7;
    logic load, bow, st;
    logic [1:0] alu_op, pc_src, inst_type;
    logic [2:0] state;
  } out_t;

  typedef struct packed {
    logic        chk, rst;
    logic [15:0] instr;
    logic        z, n, rdy;
    out_t        exp;
  } ent_t;

`ifdef MEM_WAIT_EN
  localparam int LW_LEN = 8;
  localparam int LW_MEM = 4;
`else
  localparam int LW_LEN = 5;
  localparam int LW_MEM = 1;
`endif

  ent_t q[$];
  ent_t cur;
  int   cur_idx;
  logic cur_v = 1'b0;
  int   total = 0;
  int   bad = 0;

  function automatic out_t blank(input logic [2:0] st, input logic [1:0] it);
    out_t o = '0;
    o.state = st;
    o.inst_type = it;
    return o;
  endfunction

  function automatic void push(input logic chk, input logic rst, input logic [15:0] ins,
                               input logic zz, input logic nn, input logic rdy, input out_t o);
    ent_t e;
    if (rst) begin
      o.load = 1'b0; o.reg_wr = 1'b0; o.mem_w = 1'b0;
    end
    e.chk = chk; e.rst = rst; e.instr = ins; e.z = zz; e.n = nn; e.rdy = rdy; e.exp = o;
    q.push_back(e);
  endfunction

  // Expected trace for one instruction, from the opcode table and the
  // per-class cycle sequences.
  function automatic void add_instr(input logic [15:0] ins, input logic zz, input logic nn,
                                    input int wt);
    int   op = int'(ins[15:12]);
    logic m = ins[11];
    logic r = (op <= 2), ai = (op == 3 || op == 4), ld = (op == 5 || op == 6);
    logic br = (op >= 7 && op <= 10), jl = (op >= 11 && op <= 14), sv = (op == 15);
    logic [1:0] it = r ? 2'd0 : (op <= 10) ? 2'd1 : (op == 11) ? 2'd0 : (op <= 14) ? 2'd2 : 2'd3;
    logic tk;
    int   nm;
    out_t o;
    push(1, 0, ins, zz, nn, 1'b0, blank(3'd0, 2'd0));
    o = blank(3'd1, it);
    if (jl) begin
      o.load = 1'b1;
      o.pc_src = (op == 14) ? 2'd3 : (op == 12 || op == 13) ? 2'd1 : 2'd0;
      if (op == 13) begin o.reg_wr = 1'b1; o.r7 = 1'b1; end
    end
    push(1, 0, 16'($urandom()), zz, nn, 1'b0, o);
    if (jl) return;
    o = blank(3'd2, it);
    case (op)
      0, 4:          o.alu_op = 2'd0;
      2, 7, 8, 9, 10: o.alu_op = 2'd2;
      default:       o.alu_op = 2'd1;
    endcase
    o.alu_src = (op >= 3 && op <= 6);
    o.ext_op  = (op >= 3 && op <= 10) ? m : 1'b0;
    o.reg_des = r;
    push(1, 0, 16'($urandom()), zz, nn, 1'b0, o);
    if (ld || sv) begin
`ifdef MEM_WAIT_EN
      nm = wt + 1;
`else
      nm = 1;
`endif
      for (int k = 0; k < nm; k++) begin
        logic last = (k == nm - 1);
        logic rdy;
`ifdef MEM_WAIT_EN
        rdy = last;
`else
        rdy = 1'($urandom());
`endif
        o = blank(3'd3, it);
        o.mem_r = ld;
        o.mem_w = sv;
        o.load  = sv && last;
        push(1, 0, 16'($urandom()), zz, nn, rdy, o);
      end
      if (sv) return;
    end
    o = blank(3'd4, it);
    o.load = 1'b1;
    o.reg_des = r;
    o.reg_wr = r || ai || ld;
    o.wr_b = ld;
    o.bow = (op == 6);
    case (op)
      7:  tk = zz;
      8:  tk = !zz;
      9:  tk = !zz && !nn;
      10: tk = nn;
      default: tk = 1'b0;
    endcase
    o.pc_src = (br && tk) ? 2'd2 : 2'd0;
    push(1, 0, 16'($urandom()), zz, nn, 1'b0, o);
  endfunction

  function automatic void pin(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (cur_v && cur.chk) begin
      out_t act;
      act = {AluSrc, MemR, MemW, RegWr, RegDes, WrB, ExtOp, R0, R7, load, ByteOrWord, ST,
             AluOp, PcSrc, instType, state};
      total++;
      if (act !== cur.exp) begin
        bad++;
        $display("FAIL step%0d: got state=%0d outs=%h, expected state=%0d outs=%h",
                 cur_idx, act.state, act, cur.exp.state, cur.exp);
      end
    end
  end

  initial begin
    int b, cnt;
    ent_t e;
    reset = 1'b1; instruction = '0; z = 1'b0; n = 1'b0; mem_ready = 1'b0;

    push(0, 1, 16'h0000, 0, 0, 0, blank(3'd0, 2'd0));
    push(1, 1, 16'hFFFF, 0, 0, 0, blank(3'd0, 2'd0));

    b = q.size(); add_instr(16'h1234, 0, 0, 0);
    pin("add_len", q.size() - b, 4);
    pin("add_exec_regwr", q[b+2].exp.reg_wr, 0);
    pin("add_wb_regwr", q[b+3].exp.reg_wr, 1);
    pin("add_wb_load", q[b+3].exp.load, 1);
    pin("add_wb_pcsrc", q[b+3].exp.pc_src, 0);

    b = q.size(); add_instr(16'h5A00, 0, 0, 3);
    pin("lw_len", q.size() - b, LW_LEN);
    cnt = 0;
    for (int i = b; i < q.size(); i++) cnt += int'(q[i].exp.mem_r);
    pin("lw_memr_cycles", cnt, LW_MEM);
    pin("lw_wb_wrb", q[q.size()-1].exp.wr_b, 1);
    pin("lw_wb_bow", q[q.size()-1].exp.bow, 0);

    add_instr(16'h7000, 1, 0, 0);
    pin("beq_taken_pc", q[q.size()-1].exp.pc_src, 2);
    add_instr(16'h7000, 0, 0, 0);
    pin("beq_not_taken_pc", q[q.size()-1].exp.pc_src, 0);

    b = q.size(); add_instr(16'hD000, 0, 0, 0);
    pin("call_len", q.size() - b, 2);
    pin("call_dec_regwr", q[b+1].exp.reg_wr, 1);
    pin("call_dec_r7", q[b+1].exp.r7, 1);
    pin("call_dec_pcsrc", q[b+1].exp.pc_src, 1);

    // Store interrupted by reset in its MEM cycle.
    add_instr(16'hF123, 0, 0, 0);
    e = q.pop_back();
    e.rst = 1'b1; e.rdy = 1'b0; e.exp.load = 1'b0; e.exp.mem_w = 1'b0;
    q.push_back(e);
    push(1, 1, 16'hF123, 0, 0, 0, blank(3'd0, 2'd0));

    b = q.size(); add_instr(16'hB000, 0, 0, 0);
    pin("ill_len", q.size() - b, 2);
    pin("ill_dec_load", q[b+1].exp.load, 1);

    add_instr(16'h2111, 0, 0, 0);
    add_instr(16'h0111, 0, 0, 0);
    add_instr(16'h3800, 0, 0, 0);
    add_instr(16'h4000, 0, 0, 0);
    add_instr(16'h6800, 0, 0, 1);
    add_instr(16'h8000, 0, 0, 0);
    add_instr(16'h8000, 1, 0, 0);
    add_instr(16'h9000, 0, 0, 0);
    add_instr(16'h9000, 0, 1, 0);
    add_instr(16'hA800, 0, 1, 0);
    add_instr(16'hA800, 0, 0, 0);
    add_instr(16'hC000, 0, 0, 0);
    add_instr(16'hE000, 0, 0, 0);
    add_instr(16'hF800, 0, 0, 2);
    add_instr(16'h1FFF, 1, 1, 0);

    foreach (q[i]) begin
      @(posedge clk);
      #1;
      reset = q[i].rst;
      instruction = q[i].instr;
      z = q[i].z;
      n = q[i].n;
      mem_ready = q[i].rdy;
      cur = q[i];
      cur_idx = i;
      cur_v = 1'b1;
    end
    @(posedge clk);
    #1;
    cur_v = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
